dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 34 +++
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// The arbiter state machine, the owner index type and the default
// parameter values live here so the arbiter and its parent agree on them.

package dmem_arb_pkg;

    // Default data/address width, matching the data RAM.
    localparam int DEFAULT_SIZE     = 32;

    // Default number of consecutive owned cycles before a forced handover.
    localparam int DEFAULT_MAX_HOLD = 8;

    // Width of the hold counter; wide enough for MAX_HOLD up to 255.
    localparam int HOLD_WIDTH       = 8;

    // Arbiter states: nobody owns the RAM, or port 0 / port 1 owns it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Index of a requesting port (0 = CPU data port, 1 = loader/debug port).
    typedef logic owner_t;

    localparam owner_t PORT0 = 1'b0;
    localparam owner_t PORT1 = 1'b1;

    // Ownership state that corresponds to a given port.
    function automatic arb_state_t own_state(input owner_t port);
        return (port == PORT1) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// One port at a time owns the RAM; the owner's request is forwarded
// combinationally, writes commit on the edge ending the owned cycle and
// reads return registered data with a one-cycle valid pulse.
// An owner may hold the RAM for at most MAX_HOLD consecutive cycles while
// the other port waits, unless it asserts its lock input.
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests from IDLE in favour of the port that did not own the RAM last;
// without it simultaneous requests from IDLE always go to port 0.

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int SIZE     = DEFAULT_SIZE,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic            clock,
    input  logic            nreset,

    input  logic            req0,
    input  logic            we0,
    input  logic            lock0,
    input  logic [SIZE-1:0] addr0,
    input  logic [SIZE-1:0] wdata0,

    input  logic            req1,
    input  logic            we1,
    input  logic            lock1,
    input  logic [SIZE-1:0] addr1,
    input  logic [SIZE-1:0] wdata1,

    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [SIZE-1:0] rdata0,
    output logic [SIZE-1:0] rdata1,

    output logic [SIZE-1:0] ram_address,
    output logic [SIZE-1:0] ram_data,
    output logic            ram_wren,
    output logic            ram_wread,
    input  logic [SIZE-1:0] ram_salida
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT = HOLD_WIDTH'(MAX_HOLD);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [HOLD_WIDTH-1:0] hold_count;
    owner_t                tie_port;
    logic                  read0;
    logic                  read1;
    logic                  hold_expired;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    owner_t                last_owner;
`endif

    // Winner of a simultaneous request from IDLE.
    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        tie_port = ~last_owner;
`else
        tie_port = PORT0;
`endif
    end

    // Owner has used up its hold budget (counter saturates at the limit).
    always_comb begin
        hold_expired = (hold_count == HOLD_LIMIT);
    end

    // Next owner: grant from IDLE, release, forced handover, or stay.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = own_state(tie_port);
                end else if (req0) begin
                    next_state = OWN0;
                end else if (req1) begin
                    next_state = OWN1;
                end
            end
            OWN0: begin
                if (!lock0) begin
                    if (!req0) begin
                        next_state = req1 ? OWN1 : IDLE;
                    end else if (hold_expired && req1) begin
                        next_state = OWN1;
                    end
                end
            end
            OWN1: begin
                if (!lock1) begin
                    if (!req1) begin
                        next_state = req0 ? OWN0 : IDLE;
                    end else if (hold_expired && req0) begin
                        next_state = OWN0;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Forward the owner's access to the RAM; everything is zero otherwise.
    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        ram_wread   = 1'b0;
        read0       = 1'b0;
        read1       = 1'b0;
        case (state)
            OWN0: begin
                if (req0) begin
                    ram_address = addr0;
                    ram_data    = wdata0;
                    ram_wren    = we0;
                    ram_wread   = ~we0;
                    read0       = ~we0;
                end
            end
            OWN1: begin
                if (req1) begin
                    ram_address = addr1;
                    ram_data    = wdata1;
                    ram_wren    = we1;
                    ram_wread   = ~we1;
                    read1       = ~we1;
                end
            end
            default: begin
                ram_address = '0;
            end
        endcase
    end

    // Arbiter state, registered grants, hold counter and read return path.
    // The hold counter loads 1 on a new grant so that it equals the number
    // of cycles owned so far, including the current one.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            hold_count <= '0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_owner <= PORT1;
`endif
        end else begin
            state <= next_state;
            gnt0  <= (next_state == OWN0);
            gnt1  <= (next_state == OWN1);

            if (next_state == IDLE) begin
                hold_count <= '0;
            end else if (next_state != state) begin
                hold_count <= HOLD_WIDTH'(1);
            end else if (!hold_expired) begin
                hold_count <= hold_count + HOLD_WIDTH'(1);
            end

            rvalid0 <= read0;
            rvalid1 <= read1;
            if (read0) begin
                rdata0 <= ram_salida;
            end
            if (read1) begin
                rdata1 <= ram_salida;
            end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if ((next_state != IDLE) && (next_state != state)) begin
                last_owner <= (next_state == OWN1) ? PORT1 : PORT0;
            end
`endif
        end
    end

endmodule
